// File: rtl/seg7_byte_scroller_pkg.sv
// Shared definitions for the byte scroller display stage: FSM encoding,
// blank pattern and the active-high hex font (bit0=a .. bit6=g).
package seg7_byte_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW_HI = 2'd1,
    ST_SHOW_LO = 2'd2,
    ST_GAP     = 2'd3
  } scroll_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 15 first: entry [n] is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_byte_scroller_if.sv
// Byte handshake into the display stage: producer holds data_in/data_valid
// until data_ready is seen high at a clock edge.
interface seg7_byte_scroller_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

// File: rtl/seg7_byte_scroller_hex_to_seg7.sv
// Nibble to 7-segment glyph, purely combinational; reused by other display blocks.
module hex_to_seg7
  import seg7_byte_scroller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_FONT[nibble];
endmodule

// File: rtl/seg7_byte_scroller.sv
// Shows one accepted byte on a single digit: high nibble, low nibble (with DP),
// then a blank gap, each for MAX_COUNT enabled clocks, then pulses done.
module seg7_byte_scroller
  import seg7_byte_scroller_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  seg7_byte_scroller_if.slave   bus,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [23:0] CNT_LAST = MAX_COUNT - 24'd1;

  scroll_state_e state_q, state_d;
  logic [23:0]   cnt_q;
  logic [7:0]    byte_q;
  logic          done_q;
  logic          accept;
  logic          phase_end;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  // Accept only in IDLE; ena gates everything so a frozen block ignores valid.
  assign accept    = (state_q == ST_IDLE) && bus.data_valid && ena;
  assign phase_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && ena;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: each display phase advances only when its counter expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept)    state_d = ST_SHOW_HI;
      ST_SHOW_HI: if (phase_end) state_d = ST_SHOW_LO;
      ST_SHOW_LO: if (phase_end) state_d = ST_GAP;
      ST_GAP:     if (phase_end) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Phase counter: restarts at accept and at each phase boundary, frozen by ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (ena) begin
      if (state_q == ST_IDLE || phase_end) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 24'd1;
    end
  end

  // Byte capture on accept; held for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      byte_q <= 8'h00;
    else if (accept) byte_q <= bus.data_in;
  end

  // done is high for exactly the cycle after GAP exits; ena low forces it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_q == ST_GAP) && phase_end;
  end

  assign nibble = (state_q == ST_SHOW_HI) ? byte_q[7:4] : byte_q[3:0];

  hex_to_seg7 u_font (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Display decode from registered state/byte only, so inputs cannot glitch it.
  always_comb begin
    seg_out = SEG_BLANK;
    dp_out  = 1'b0;
    unique case (state_q)
      ST_SHOW_HI: seg_out = glyph;
      ST_SHOW_LO: begin
        seg_out = glyph;
        dp_out  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign bus.data_ready = (state_q == ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_seg7_byte_scroller.sv
// Scoreboard bench: two builds (MAX_COUNT=4 and =1). Each accepted byte pushes
// its expected per-cycle output trace; monitors pop one entry per enabled edge.
module tb_seg7_byte_scroller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, busy0, busy1, done0, done1;
  logic ena_e;
  int n_cmp = 0;
  int n_bad = 0;

  // {seg[6:0], dp, busy, ready, done}
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] held0, held1;

  localparam logic [10:0] IDLE_EXP = 11'h000 | 11'b0000000_0_0_1_0;

  seg7_byte_scroller_if if0 ();
  seg7_byte_scroller_if if1 ();

  seg7_byte_scroller #(.MAX_COUNT(24'd4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if0),
    .seg_out(seg0), .dp_out(dp0), .busy(busy0), .done(done0));

  seg7_byte_scroller #(.MAX_COUNT(24'd1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if1),
    .seg_out(seg1), .dp_out(dp1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
      4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
      4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
      4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
    endcase
  endfunction

  function automatic logic [10:0] mk(input logic [6:0] s, input logic dp, busy, dn);
    mk = {s, dp, busy, ~busy, dn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  // Expected trace for one byte: hi, lo(dp), gap for pc cycles each, then done.
  task automatic push_trace(input int which, input logic [7:0] b);
    int pc;
    pc = (which == 0) ? 4 : 1;
    for (int i = 0; i < pc; i++)
      if (which == 0) q0.push_back(mk(font(b[7:4]), 1'b0, 1'b1, 1'b0));
      else            q1.push_back(mk(font(b[7:4]), 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < pc; i++)
      if (which == 0) q0.push_back(mk(font(b[3:0]), 1'b1, 1'b1, 1'b0));
      else            q1.push_back(mk(font(b[3:0]), 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < pc; i++)
      if (which == 0) q0.push_back(mk(7'h00, 1'b0, 1'b1, 1'b0));
      else            q1.push_back(mk(7'h00, 1'b0, 1'b1, 1'b0));
    if (which == 0) q0.push_back(mk(7'h00, 1'b0, 1'b0, 1'b1));
    else            q1.push_back(mk(7'h00, 1'b0, 1'b0, 1'b1));
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int which, input logic [7:0] b);
    logic acc;
    logic rdy;
    acc = 1'b0;
    if (which == 0) begin if0.data_in = b; if0.data_valid = 1'b1; end
    else            begin if1.data_in = b; if1.data_valid = 1'b1; end
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      rdy = (which == 0) ? if0.data_ready : if1.data_ready;
      @(posedge clk);
      acc = rdy && ena && rst_n;
      #1;
    end
    if (acc) push_trace(which, b);
    else     chk("accept_timeout", 32'(acc), 32'd1);
    if (which == 0) if0.data_valid = 1'b0;
    else            if1.data_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) ena_e <= ena;

  // Monitor for the MAX_COUNT=4 build.
  always @(negedge clk) begin
    automatic logic [10:0] e;
    if (!rst_n)    e = IDLE_EXP;
    else if (ena_e) e = (q0.size() > 0) ? q0.pop_front() : IDLE_EXP;
    else           e = {held0[10:1], 1'b0};
    held0 <= e;
    chk("dut4", 32'({seg0, dp0, busy0, if0.data_ready, done0}), 32'(e));
  end

  // Monitor for the MAX_COUNT=1 build.
  always @(negedge clk) begin
    automatic logic [10:0] e;
    if (!rst_n)    e = IDLE_EXP;
    else if (ena_e) e = (q1.size() > 0) ? q1.pop_front() : IDLE_EXP;
    else           e = {held1[10:1], 1'b0};
    held1 <= e;
    chk("dut1", 32'({seg1, dp1, busy1, if1.data_ready, done1}), 32'(e));
  end

  initial begin
    if0.data_in = 8'h00; if0.data_valid = 1'b0;
    if1.data_in = 8'h00; if1.data_valid = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Basic byte, then idle.
    send(0, 8'hA5);
    cycles(16);

    // Second byte arrives while busy and is held until the done cycle.
    send(0, 8'h12);
    cycles(2);
    send(0, 8'h3C);
    cycles(16);

    // ena low for 10 cycles inside SHOW_HI.
    send(0, 8'hF0);
    cycles(1);
    ena = 1'b0;
    cycles(10);
    ena = 1'b1;
    cycles(16);

    // All 16 glyphs in both nibble positions, back to back.
    for (int n = 0; n < 16; n++) send(0, {4'(n), 4'(15 - n)});
    cycles(16);

    // Single-cycle phases.
    send(1, 8'h9E);
    cycles(6);

    // Reset in the middle of SHOW_LO discards the byte.
    send(0, 8'h77);
    cycles(5);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    cycles(2);
    rst_n = 1'b1;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
